// File: rtl/issue_pkg.sv
// Shared definitions for the issue stage: default widths, RV32I opcodes,
// immediate formats and the immediate generator.
package issue_pkg;

    localparam int unsigned XLEN_DEF        = 32;
    localparam int unsigned ROB_IDX_W_DEF   = 4;
    localparam int unsigned CDB_PORTS_DEF   = 2;
    localparam int unsigned QUEUE_DEPTH_DEF = 4;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_type_e;

    // Reassemble the 32-bit immediate of the given format.
    function automatic logic [31:0] gen_imm(input imm_type_e t, input logic [31:0] inst);
        logic [31:0] imm;
        case (t)
            IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
            IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   imm = {inst[31:12], 12'b0};
            IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/issue_if.sv
// Fetch-to-issue handshake: one instruction per transfer when valid && ready.
interface issue_if
    import issue_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;
    logic            in_pred_taken;

    modport master (output in_valid, in_inst, in_pc, in_pred_taken, input in_ready);
    modport slave  (input in_valid, in_inst, in_pc, in_pred_taken, output in_ready);
endinterface

// File: rtl/issue_fifo.sv
// Circular instruction queue with head/tail pointers, occupancy count and flush.
module issue_fifo #(
    parameter int unsigned WIDTH = 65,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         push_data,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    assign head_data = mem[head];
    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);

    // Storage write; contents need no reset since count qualifies them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= push_data;
        end
    end

    // Pointer and occupancy update; flush clears the queue outright.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/issue_stage.sv
// Buffered decode/issue stage: queues fetched RV32I instructions, decodes the
// head, resolves operands from regfile/CDB/ROB and issues one per cycle.
module issue_stage
    import issue_pkg::*;
#(
    parameter int unsigned XLEN        = XLEN_DEF,
    parameter int unsigned ROB_IDX_W   = ROB_IDX_W_DEF,
    parameter int unsigned CDB_PORTS   = CDB_PORTS_DEF,
    parameter int unsigned QUEUE_DEPTH = QUEUE_DEPTH_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           rdy,
    input  logic                           rollback,
    issue_if.slave                         fetch,
    input  logic                           rob_full,
    input  logic                           rs_full,
    input  logic                           lsb_full,
    input  logic [ROB_IDX_W-1:0]           rob_tail,
    output logic [4:0]                     reg_rs1,
    output logic [4:0]                     reg_rs2,
    input  logic                           reg_rs1_busy,
    input  logic [XLEN-1:0]                reg_rs1_val,
    input  logic [ROB_IDX_W-1:0]           reg_rs1_tag,
    input  logic                           reg_rs2_busy,
    input  logic [XLEN-1:0]                reg_rs2_val,
    input  logic [ROB_IDX_W-1:0]           reg_rs2_tag,
    output logic [ROB_IDX_W-1:0]           rob_q1_tag,
    output logic [ROB_IDX_W-1:0]           rob_q2_tag,
    input  logic                           rob_q1_ready,
    input  logic [XLEN-1:0]                rob_q1_val,
    input  logic                           rob_q2_ready,
    input  logic [XLEN-1:0]                rob_q2_val,
    input  logic [CDB_PORTS-1:0]           cdb_valid,
    input  logic [CDB_PORTS*ROB_IDX_W-1:0] cdb_tag,
    input  logic [CDB_PORTS*XLEN-1:0]      cdb_val,
    output logic                           rename_en,
    output logic [4:0]                     rename_rd,
    output logic [ROB_IDX_W-1:0]           rename_tag,
    output logic                           out_issue,
    output logic                           out_rs_en,
    output logic                           out_lsb_en,
    output logic                           out_is_store,
    output logic                           out_illegal,
    output logic [ROB_IDX_W-1:0]           out_rob_tag,
    output logic [4:0]                     out_rd,
    output logic [6:0]                     out_opcode,
    output logic [2:0]                     out_funct3,
    output logic                           out_funct7,
    output logic                           out_rs1_rdy,
    output logic [XLEN-1:0]                out_rs1_val,
    output logic [ROB_IDX_W-1:0]           out_rs1_tag,
    output logic                           out_rs2_rdy,
    output logic [XLEN-1:0]                out_rs2_val,
    output logic [ROB_IDX_W-1:0]           out_rs2_tag,
    output logic [XLEN-1:0]                out_imm,
    output logic [XLEN-1:0]                out_pc,
    output logic                           out_pred_taken
);
    localparam int unsigned ENTRY_W = 32 + XLEN + 1;

    typedef struct packed {
        logic                 rdy;
        logic [ROB_IDX_W-1:0] tag;
        logic [XLEN-1:0]      val;
    } operand_t;

    logic [ENTRY_W-1:0]         head_entry;
    logic [31:0]                h_inst;
    logic [XLEN-1:0]            h_pc;
    logic                       h_pred;
    logic [$clog2(QUEUE_DEPTH):0] q_count;
    logic                       q_full, q_empty, push, issue_go;
    logic [6:0]                 opcode;
    imm_type_e                  imm_type;
    logic                       use1, use2, to_lsb, is_store, illegal, funct7, route_ok;
    logic [4:0]                 rd;
    logic [31:0]                imm32;
    operand_t                   op1, op2;

    // Operand lookup order: free register, then lowest matching CDB port, then ROB.
    function automatic operand_t resolve(
        input logic                           used,
        input logic [4:0]                     src,
        input logic                           busy,
        input logic [XLEN-1:0]                rval,
        input logic [ROB_IDX_W-1:0]           rtag,
        input logic [CDB_PORTS-1:0]           c_valid,
        input logic [CDB_PORTS*ROB_IDX_W-1:0] c_tag,
        input logic [CDB_PORTS*XLEN-1:0]      c_val,
        input logic                           rob_ready,
        input logic [XLEN-1:0]                rob_val
    );
        operand_t op;
        logic     hit;
        op     = '0;
        op.rdy = 1'b1;
        hit    = 1'b0;
        if (used && src != 5'd0) begin
            if (!busy) begin
                op.val = rval;
            end else begin
                for (int unsigned p = 0; p < CDB_PORTS; p++) begin
                    if (!hit && c_valid[p] && c_tag[p*ROB_IDX_W +: ROB_IDX_W] == rtag) begin
                        hit    = 1'b1;
                        op.val = c_val[p*XLEN +: XLEN];
                    end
                end
                if (!hit) begin
                    if (rob_ready) begin
                        op.val = rob_val;
                    end else begin
                        op.rdy = 1'b0;
                        op.tag = rtag;
                    end
                end
            end
        end
        return op;
    endfunction

    assign {h_pred, h_pc, h_inst} = head_entry;
    assign fetch.in_ready = !rst && rdy && !rollback && !q_full;
    assign push           = fetch.in_valid && fetch.in_ready;

    issue_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (rollback),
        .push      (push),
        .pop       (issue_go),
        .push_data ({fetch.in_pred_taken, fetch.in_pc, fetch.in_inst}),
        .head_data (head_entry),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    assign reg_rs1    = h_inst[19:15];
    assign reg_rs2    = h_inst[24:20];
    assign rob_q1_tag = reg_rs1_tag;
    assign rob_q2_tag = reg_rs2_tag;

    // Decode the queue head: immediate format, operand use, routing, rd/funct7.
    always_comb begin
        opcode   = h_inst[6:0];
        imm_type = IMM_NONE;
        use1     = 1'b0;
        use2     = 1'b0;
        to_lsb   = 1'b0;
        is_store = 1'b0;
        illegal  = 1'b0;
        funct7   = 1'b0;
        rd       = h_inst[11:7];
        case (opcode)
            OPC_LUI, OPC_AUIPC: imm_type = IMM_U;
            OPC_JAL:            imm_type = IMM_J;
            OPC_JALR: begin
                imm_type = IMM_I;
                use1     = 1'b1;
            end
            OPC_BRANCH: begin
                imm_type = IMM_B;
                use1     = 1'b1;
                use2     = 1'b1;
                rd       = 5'd0;
            end
            OPC_LOAD: begin
                imm_type = IMM_I;
                use1     = 1'b1;
                to_lsb   = 1'b1;
            end
            OPC_STORE: begin
                imm_type = IMM_S;
                use1     = 1'b1;
                use2     = 1'b1;
                to_lsb   = 1'b1;
                is_store = 1'b1;
                rd       = 5'd0;
            end
            OPC_OPIMM: begin
                imm_type = IMM_I;
                use1     = 1'b1;
                funct7   = (h_inst[14:12] == 3'b101) ? h_inst[30] : 1'b0;
            end
            OPC_OP: begin
                use1   = 1'b1;
                use2   = 1'b1;
                funct7 = h_inst[30];
            end
            default: illegal = 1'b1;
        endcase
    end

    // Operand resolution, immediate and the issue decision for this cycle.
    always_comb begin
        imm32 = gen_imm(imm_type, h_inst);
        op1   = resolve(use1, reg_rs1, reg_rs1_busy, reg_rs1_val, reg_rs1_tag,
                        cdb_valid, cdb_tag, cdb_val, rob_q1_ready, rob_q1_val);
        op2   = resolve(use2, reg_rs2, reg_rs2_busy, reg_rs2_val, reg_rs2_tag,
                        cdb_valid, cdb_tag, cdb_val, rob_q2_ready, rob_q2_val);
        route_ok   = illegal ? 1'b1 : (to_lsb ? !lsb_full : !rs_full);
        issue_go   = !rst && rdy && !rollback && !q_empty && !rob_full && route_ok;
        rename_en  = issue_go && (rd != 5'd0) && !illegal;
        rename_rd  = rd;
        rename_tag = rob_tail;
    end

    // Issue register: loads on issue, otherwise holds with out_issue cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_issue      <= 1'b0;
            out_rs_en      <= 1'b0;
            out_lsb_en     <= 1'b0;
            out_is_store   <= 1'b0;
            out_illegal    <= 1'b0;
            out_rob_tag    <= '0;
            out_rd         <= '0;
            out_opcode     <= '0;
            out_funct3     <= '0;
            out_funct7     <= 1'b0;
            out_rs1_rdy    <= 1'b0;
            out_rs1_val    <= '0;
            out_rs1_tag    <= '0;
            out_rs2_rdy    <= 1'b0;
            out_rs2_val    <= '0;
            out_rs2_tag    <= '0;
            out_imm        <= '0;
            out_pc         <= '0;
            out_pred_taken <= 1'b0;
        end else if (!issue_go) begin
            out_issue <= 1'b0;
        end else begin
            out_issue      <= 1'b1;
            out_rs_en      <= !illegal && !to_lsb;
            out_lsb_en     <= !illegal && to_lsb;
            out_is_store   <= is_store;
            out_illegal    <= illegal;
            out_rob_tag    <= rob_tail;
            out_rd         <= rd;
            out_opcode     <= opcode;
            out_funct3     <= h_inst[14:12];
            out_funct7     <= funct7;
            out_rs1_rdy    <= op1.rdy;
            out_rs1_val    <= op1.val;
            out_rs1_tag    <= op1.tag;
            out_rs2_rdy    <= op2.rdy;
            out_rs2_val    <= op2.val;
            out_rs2_tag    <= op2.tag;
            out_imm        <= XLEN'($signed(imm32));
            out_pc         <= h_pc;
            out_pred_taken <= h_pred;
        end
    end

endmodule

// File: tb/tb_issue_stage.sv
// Directed bench for issue_stage: one task per scenario, inline comparisons.
module tb_issue_stage;
    localparam int unsigned XLEN = 32;
    localparam int unsigned RW   = 4;
    localparam int unsigned CP   = 2;
    localparam int unsigned QD   = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, rdy, rollback, rob_full, rs_full, lsb_full;
    logic [RW-1:0] rob_tail;
    logic [4:0] reg_rs1, reg_rs2;
    logic reg_rs1_busy, reg_rs2_busy, rob_q1_ready, rob_q2_ready;
    logic [XLEN-1:0] reg_rs1_val, reg_rs2_val, rob_q1_val, rob_q2_val;
    logic [RW-1:0] reg_rs1_tag, reg_rs2_tag, rob_q1_tag, rob_q2_tag;
    logic [CP-1:0] cdb_valid;
    logic [CP*RW-1:0] cdb_tag;
    logic [CP*XLEN-1:0] cdb_val;
    logic rename_en;
    logic [4:0] rename_rd;
    logic [RW-1:0] rename_tag;
    logic out_issue, out_rs_en, out_lsb_en, out_is_store, out_illegal, out_funct7;
    logic [RW-1:0] out_rob_tag, out_rs1_tag, out_rs2_tag;
    logic [4:0] out_rd;
    logic [6:0] out_opcode;
    logic [2:0] out_funct3;
    logic out_rs1_rdy, out_rs2_rdy, out_pred_taken;
    logic [XLEN-1:0] out_rs1_val, out_rs2_val, out_imm, out_pc;

    int checks = 0;
    int errors = 0;

    issue_if #(.XLEN(XLEN)) fetch_bus ();

    issue_stage #(
        .XLEN(XLEN), .ROB_IDX_W(RW), .CDB_PORTS(CP), .QUEUE_DEPTH(QD)
    ) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .fetch(fetch_bus),
        .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full), .rob_tail(rob_tail),
        .reg_rs1(reg_rs1), .reg_rs2(reg_rs2),
        .reg_rs1_busy(reg_rs1_busy), .reg_rs1_val(reg_rs1_val), .reg_rs1_tag(reg_rs1_tag),
        .reg_rs2_busy(reg_rs2_busy), .reg_rs2_val(reg_rs2_val), .reg_rs2_tag(reg_rs2_tag),
        .rob_q1_tag(rob_q1_tag), .rob_q2_tag(rob_q2_tag),
        .rob_q1_ready(rob_q1_ready), .rob_q1_val(rob_q1_val),
        .rob_q2_ready(rob_q2_ready), .rob_q2_val(rob_q2_val),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
        .rename_en(rename_en), .rename_rd(rename_rd), .rename_tag(rename_tag),
        .out_issue(out_issue), .out_rs_en(out_rs_en), .out_lsb_en(out_lsb_en),
        .out_is_store(out_is_store), .out_illegal(out_illegal), .out_rob_tag(out_rob_tag),
        .out_rd(out_rd), .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
        .out_rs1_rdy(out_rs1_rdy), .out_rs1_val(out_rs1_val), .out_rs1_tag(out_rs1_tag),
        .out_rs2_rdy(out_rs2_rdy), .out_rs2_val(out_rs2_val), .out_rs2_tag(out_rs2_tag),
        .out_imm(out_imm), .out_pc(out_pc), .out_pred_taken(out_pred_taken)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_defaults();
        rdy = 1'b1; rollback = 1'b0;
        fetch_bus.in_valid = 1'b0; fetch_bus.in_inst = '0;
        fetch_bus.in_pc = '0; fetch_bus.in_pred_taken = 1'b0;
        rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0; rob_tail = '0;
        reg_rs1_busy = 1'b0; reg_rs1_val = '0; reg_rs1_tag = '0;
        reg_rs2_busy = 1'b0; reg_rs2_val = '0; reg_rs2_tag = '0;
        rob_q1_ready = 1'b0; rob_q1_val = '0; rob_q2_ready = 1'b0; rob_q2_val = '0;
        cdb_valid = '0; cdb_tag = '0; cdb_val = '0;
    endtask

    // Present one instruction for a single accepting edge.
    task automatic enqueue(input logic [31:0] inst, input logic [31:0] pc, input logic pred);
        fetch_bus.in_inst = inst; fetch_bus.in_pc = pc; fetch_bus.in_pred_taken = pred;
        fetch_bus.in_valid = 1'b1;
        tick();
        fetch_bus.in_valid = 1'b0;
        #1;
    endtask

    function automatic logic [31:0] addi(input int unsigned rd, input int unsigned imm);
        logic [31:0] v;
        v = (32'(imm) << 20) | (32'(rd) << 7) | 32'h13;
        return v;
    endfunction

    task automatic test_reset();
        set_defaults();
        rst = 1'b1;
        tick(); tick();
        checks++; if (fetch_bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", fetch_bus.in_ready); end
        checks++; if (out_issue !== 1'b0) begin errors++; $display("FAIL reset_out_issue got %b want 0", out_issue); end
        checks++; if (out_imm !== 32'h0) begin errors++; $display("FAIL reset_out_imm got %h want 0", out_imm); end
        checks++; if (out_rob_tag !== 4'h0) begin errors++; $display("FAIL reset_out_rob_tag got %h want 0", out_rob_tag); end
        rst = 1'b0;
        #1;
        checks++; if (fetch_bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b want 1", fetch_bus.in_ready); end
    endtask

    task automatic test_addi();
        set_defaults();
        rob_tail = 4'd3;
        enqueue(32'hFFB00093, 32'h100, 1'b1);
        checks++; if (out_issue !== 1'b0) begin errors++; $display("FAIL addi_early_issue got %b want 0", out_issue); end
        checks++; if ({rename_en, rename_rd, rename_tag} !== {1'b1, 5'd1, 4'd3}) begin errors++; $display("FAIL addi_rename got %b/%0d/%0d want 1/1/3", rename_en, rename_rd, rename_tag); end
        tick();
        checks++; if (out_issue !== 1'b1) begin errors++; $display("FAIL addi_issue got %b want 1", out_issue); end
        checks++; if ({out_rs_en, out_lsb_en, out_illegal} !== 3'b100) begin errors++; $display("FAIL addi_route got %b want 100", {out_rs_en, out_lsb_en, out_illegal}); end
        checks++; if (out_imm !== 32'hFFFFFFFB) begin errors++; $display("FAIL addi_imm got %h want fffffffb", out_imm); end
        checks++; if ({out_funct7, out_rd, out_rob_tag, out_opcode} !== {1'b0, 5'd1, 4'd3, 7'h13}) begin errors++; $display("FAIL addi_fields got %b/%0d/%0d/%h want 0/1/3/13", out_funct7, out_rd, out_rob_tag, out_opcode); end
        checks++; if ({out_rs1_rdy, out_rs1_val, out_pc, out_pred_taken} !== {1'b1, 32'h0, 32'h100, 1'b1}) begin errors++; $display("FAIL addi_ops got %b/%h/%h/%b want 1/0/100/1", out_rs1_rdy, out_rs1_val, out_pc, out_pred_taken); end
        tick();
        checks++; if (out_issue !== 1'b0) begin errors++; $display("FAIL addi_pulse got %b want 0", out_issue); end
    endtask

    task automatic test_store_cdb();
        set_defaults();
        rob_tail = 4'd7;
        reg_rs1_val = 32'h1000;
        reg_rs2_busy = 1'b1; reg_rs2_tag = 4'd5;
        cdb_valid = 2'b10; cdb_tag = {4'd5, 4'd7}; cdb_val = {32'h55, 32'h0};
        enqueue(32'h0020A623, 32'h200, 1'b0);
        checks++; if ({reg_rs1, reg_rs2, rob_q2_tag} !== {5'd1, 5'd2, 4'd5}) begin errors++; $display("FAIL sw_query got %0d/%0d/%0d want 1/2/5", reg_rs1, reg_rs2, rob_q2_tag); end
        checks++; if (rename_en !== 1'b0) begin errors++; $display("FAIL sw_rename got %b want 0", rename_en); end
        tick();
        checks++; if ({out_issue, out_rs_en, out_lsb_en, out_is_store} !== 4'b1011) begin errors++; $display("FAIL sw_route got %b want 1011", {out_issue, out_rs_en, out_lsb_en, out_is_store}); end
        checks++; if ({out_imm, out_rd, out_rob_tag} !== {32'd12, 5'd0, 4'd7}) begin errors++; $display("FAIL sw_fields got %h/%0d/%0d want c/0/7", out_imm, out_rd, out_rob_tag); end
        checks++; if ({out_rs1_val, out_rs2_rdy, out_rs2_val} !== {32'h1000, 1'b1, 32'h55}) begin errors++; $display("FAIL sw_ops got %h/%b/%h want 1000/1/55", out_rs1_val, out_rs2_rdy, out_rs2_val); end
    endtask

    task automatic test_branch();
        set_defaults();
        reg_rs1_busy = 1'b1; reg_rs1_tag = 4'd6;
        cdb_valid = 2'b11; cdb_tag = {4'd6, 4'd6}; cdb_val = {32'h22, 32'h11};
        reg_rs2_busy = 1'b1; reg_rs2_tag = 4'd9;
        rob_q2_ready = 1'b1; rob_q2_val = 32'h99;
        enqueue(32'hFE208CE3, 32'h300, 1'b0);
        checks++; if (rob_q1_tag !== 4'd6) begin errors++; $display("FAIL beq_q1_tag got %0d want 6", rob_q1_tag); end
        tick();
        checks++; if ({out_issue, out_rs_en, out_rd} !== {1'b1, 1'b1, 5'd0}) begin errors++; $display("FAIL beq_route got %b/%b/%0d want 1/1/0", out_issue, out_rs_en, out_rd); end
        checks++; if (out_imm !== 32'hFFFFFFF8) begin errors++; $display("FAIL beq_imm got %h want fffffff8", out_imm); end
        checks++; if ({out_rs1_rdy, out_rs1_val} !== {1'b1, 32'h11}) begin errors++; $display("FAIL beq_rs1_cdb got %b/%h want 1/11", out_rs1_rdy, out_rs1_val); end
        checks++; if ({out_rs2_rdy, out_rs2_val} !== {1'b1, 32'h99}) begin errors++; $display("FAIL beq_rs2_rob got %b/%h want 1/99", out_rs2_rdy, out_rs2_val); end
    endtask

    task automatic test_srai();
        set_defaults();
        reg_rs1_busy = 1'b1; reg_rs1_tag = 4'hA;
        reg_rs2_val = 32'hDEAD;
        enqueue(32'h4021D193, 32'h400, 1'b0);
        tick();
        checks++; if ({out_issue, out_funct7, out_funct3, out_rd} !== {1'b1, 1'b1, 3'b101, 5'd3}) begin errors++; $display("FAIL srai_fields got %b/%b/%b/%0d want 1/1/101/3", out_issue, out_funct7, out_funct3, out_rd); end
        checks++; if (out_imm !== 32'h402) begin errors++; $display("FAIL srai_imm got %h want 402", out_imm); end
        checks++; if ({out_rs1_rdy, out_rs1_tag, out_rs1_val} !== {1'b0, 4'hA, 32'h0}) begin errors++; $display("FAIL srai_rs1_wait got %b/%h/%h want 0/a/0", out_rs1_rdy, out_rs1_tag, out_rs1_val); end
        checks++; if ({out_rs2_rdy, out_rs2_val} !== {1'b1, 32'h0}) begin errors++; $display("FAIL srai_rs2_unused got %b/%h want 1/0", out_rs2_rdy, out_rs2_val); end
    endtask

    task automatic test_illegal();
        set_defaults();
        rs_full = 1'b1; lsb_full = 1'b1;
        enqueue(32'h00000FFF, 32'h500, 1'b0);
        checks++; if (rename_en !== 1'b0) begin errors++; $display("FAIL illegal_rename got %b want 0", rename_en); end
        tick();
        checks++; if ({out_issue, out_illegal, out_rs_en, out_lsb_en} !== 4'b1100) begin errors++; $display("FAIL illegal_route got %b want 1100", {out_issue, out_illegal, out_rs_en, out_lsb_en}); end
    endtask

    task automatic test_back_to_back();
        set_defaults();
        rs_full = 1'b1;
        for (int unsigned k = 1; k <= 4; k++) begin
            checks++; if (fetch_bus.in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_%0d got %b want 1", k, fetch_bus.in_ready); end
            enqueue(addi(k, k), 32'h600 + 32'(k), 1'b0);
        end
        checks++; if (fetch_bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", fetch_bus.in_ready); end
        enqueue(addi(5, 5), 32'h605, 1'b0);
        rs_full = 1'b0;
        #1;
        checks++; if ({fetch_bus.in_ready, rename_en} !== 2'b01) begin errors++; $display("FAIL full_dequeue_ready got %b want 01", {fetch_bus.in_ready, rename_en}); end
        for (int unsigned k = 1; k <= 4; k++) begin
            tick();
            checks++; if ({out_issue, out_rd} !== {1'b1, 5'(k)}) begin errors++; $display("FAIL b2b_issue_%0d got %b/%0d want 1/%0d", k, out_issue, out_rd, k); end
        end
        tick();
        checks++; if (out_issue !== 1'b0) begin errors++; $display("FAIL b2b_drained got %b want 0", out_issue); end
    endtask

    task automatic test_rollback();
        set_defaults();
        rs_full = 1'b1;
        for (int unsigned k = 1; k <= 3; k++) enqueue(addi(k, k), 32'h700, 1'b0);
        fetch_bus.in_inst = addi(4, 4); fetch_bus.in_valid = 1'b1;
        rollback = 1'b1; rs_full = 1'b0;
        #1;
        checks++; if (fetch_bus.in_ready !== 1'b0) begin errors++; $display("FAIL rb_in_ready got %b want 0", fetch_bus.in_ready); end
        tick();
        rollback = 1'b0; fetch_bus.in_valid = 1'b0;
        checks++; if (out_issue !== 1'b0) begin errors++; $display("FAIL rb_issue got %b want 0", out_issue); end
        #1;
        checks++; if ({fetch_bus.in_ready, rename_en} !== 2'b10) begin errors++; $display("FAIL rb_empty got %b want 10", {fetch_bus.in_ready, rename_en}); end
        tick();
        checks++; if (out_issue !== 1'b0) begin errors++; $display("FAIL rb_dropped got %b want 0", out_issue); end
    endtask

    task automatic test_rdy_low();
        set_defaults();
        rdy = 1'b0;
        fetch_bus.in_inst = addi(1, 1); fetch_bus.in_valid = 1'b1;
        #1;
        checks++; if (fetch_bus.in_ready !== 1'b0) begin errors++; $display("FAIL rdy_low_ready got %b want 0", fetch_bus.in_ready); end
        tick();
        rdy = 1'b1; fetch_bus.in_valid = 1'b0;
        #1;
        checks++; if (rename_en !== 1'b0) begin errors++; $display("FAIL rdy_low_no_enq got %b want 0", rename_en); end
        tick();
        checks++; if (out_issue !== 1'b0) begin errors++; $display("FAIL rdy_low_issue got %b want 0", out_issue); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_store_cdb();
        test_branch();
        test_srai();
        test_illegal();
        test_back_to_back();
        test_rollback();
        test_rdy_low();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
